neopixel_rx: RTL
================

Name: neopixel_rx

Overview:
- Single-wire WS2812-style NRZ receiver: the decode end of the neopixel link our transmitter drives.
- Recovers bits from the high-pulse width and assembles them into bytes.
- Captures a full frame of NUM_BYTES bytes and publishes it on a parallel framebuf once a valid latch (long low) is seen.
- Used for loopback verification of the transmitter and for daisy-chain input capture; runs on the same 20 MHz clk.

Parameters:
- NUM_BYTES, 48, bytes per frame; framebuf width is 8*NUM_BYTES.
- BIT_THRESH, 12, synced high width (cycles) at or above which a bit decodes as 1.
- MIN_HIGH, 3, high pulses shorter than this are an error.
- MAX_HIGH, 40, high pulses reaching this count are an error (stuck high).
- RESET_CYCLES, 1000, low length (50 us at 20 MHz) that marks sync/latch.

Ports:
- clk  in  1  20 MHz clock.
- nrst  in  1  reset, asynchronous, active-low.
- din  in  1  serial line, asynchronous to clk.
- framebuf  out  8*NUM_BYTES  last good frame; byte k at [8k +: 8].
- frame_valid  out  1  one-cycle pulse when framebuf is updated.
- byte_data  out  8  most recently completed byte.
- byte_valid  out  1  one-cycle pulse per completed byte.
- frame_err  out  1  one-cycle pulse on any protocol error.

Behaviour:
- Reset (async, nrst low): all outputs 0, all counters 0, FSM to SYNC_WAIT, synchronizer flops cleared. Takes effect immediately, including mid-frame.
- Input path:
  - din passes through a 2-flop synchronizer, then an edge-detect register.
  - All timing below is in synced cycles; input-to-decision latency is 3 clk.
- FSM states:
  - SYNC_WAIT: count consecutive low cycles; any high clears the count. When the count reaches RESET_CYCLES, go to ARMED. Data before the first full sync is ignored and produces no errors.
  - ARMED: line low, waiting. On a rising edge, go to HIGH with the high count at 1 and the shadow byte/bit counters cleared.
  - HIGH: increment the high count.
    - If it reaches MAX_HIGH: pulse frame_err, go to SYNC_WAIT.
    - On a falling edge with high count < MIN_HIGH: pulse frame_err, go to SYNC_WAIT.
    - Otherwise on a falling edge: bit = (high count >= BIT_THRESH), go to LOW with the low count at 1.
  - LOW: increment the low count.
    - On a rising edge, go to HIGH with the high count at 1 (low width is not checked).
    - If the low count reaches RESET_CYCLES, run the end-of-frame check (below), then go to ARMED.
- Bit assembly:
  - Bits are received LSB first: the first bit of a byte lands in bit 0.
  - On the 8th bit the byte is written to shadow[8*byte_idx +: 8], byte_data is updated, and byte_valid pulses on the cycle after the decoding falling edge.
  - byte_idx then increments, saturating at NUM_BYTES.
  - Bytes beyond NUM_BYTES set an overflow flag and are not stored, but byte_valid still pulses.
- End-of-frame check:
  - Good frame: byte_idx == NUM_BYTES, bit count 0, no overflow. Copy shadow to framebuf and pulse frame_valid in the same cycle.
  - Any other case: pulse frame_err; framebuf holds its previous value.
  - Exception: an empty frame (0 bits) produces no pulse.
- Simultaneity and counters:
  - frame_valid and frame_err are mutually exclusive.
  - Counters saturate and never wrap.
  - The low counter is clog2(RESET_CYCLES+1) bits wide.
  - The shadow buffer and byte/bit counters clear on entry to ARMED.

Test Plan:
- Power-up, din low 1000 cycles, then 48 bytes of 0xA5 using T0H=8/T0L=17 and T1H=16/T1L=9 cycles, then low 1000 -> 48 byte_valid pulses with byte_data=0xA5, exactly one frame_valid, framebuf={48{8'hA5}}, no frame_err.
- Threshold boundary: one frame whose byte 0 uses high widths of 11 for bits 0-3 and 12 for bits 4-7 -> byte_data=0xF0; widths of 2 -> frame_err, FSM returns to SYNC_WAIT.
- Short frame: sync, 10 bytes of 0x3C, reset low -> 10 byte_valid pulses, frame_err pulse, framebuf unchanged from the previous good frame; a following good frame of 0x11 updates it.
- Partial and over-length frames:
  - 48 bytes plus 5 extra bits, then reset low -> frame_err, no frame_valid.
  - 49 bytes -> 49 byte_valid pulses, frame_err.
- Stuck high mid-frame: din held high 40 cycles during byte 3 -> frame_err; bits after that are ignored until 1000 low cycles; the next good frame is accepted.
- Data without leading sync: toggling begins right after nrst rises -> no byte_valid or frame_err until a 1000-cycle low. Then assert nrst low mid-byte -> all outputs 0 immediately.

Source files
------------

// File: rtl/neopixel_rx.sv
// WS2812-style NRZ receiver: decodes high-pulse widths into bits, assembles
// LSB-first bytes and publishes a full frame after a valid latch (long low).
//
// state     | meaning
// SYNC_WAIT | counting consecutive low cycles, decoding disabled
// ARMED     | synced and idle, waiting for the first rising edge of a frame
// HIGH      | measuring a high pulse
// LOW       | between bits, watching for the next rise or the latch low
module neopixel_rx #(
  parameter int NUM_BYTES    = 48,
  parameter int BIT_THRESH   = 12,
  parameter int MIN_HIGH     = 3,
  parameter int MAX_HIGH     = 40,
  parameter int RESET_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   din,
  output logic [8*NUM_BYTES-1:0] framebuf,
  output logic                   frame_valid,
  output logic [7:0]             byte_data,
  output logic                   byte_valid,
  output logic                   frame_err
);

  localparam int HW = $clog2(MAX_HIGH + 1);
  localparam int LW = $clog2(RESET_CYCLES + 1);
  localparam int BW = $clog2(NUM_BYTES + 1);

  localparam logic [HW-1:0] HIGH_MAX  = HW'(MAX_HIGH);
  localparam logic [HW-1:0] HIGH_LAST = HW'(MAX_HIGH - 1);
  localparam logic [HW-1:0] HIGH_MIN  = HW'(MIN_HIGH);
  localparam logic [HW-1:0] HIGH_THR  = HW'(BIT_THRESH);
  localparam logic [LW-1:0] LOW_MAX   = LW'(RESET_CYCLES);
  localparam logic [LW-1:0] LOW_LAST  = LW'(RESET_CYCLES - 1);
  localparam logic [BW-1:0] BYTES_MAX = BW'(NUM_BYTES);

  typedef enum logic [1:0] {SYNC_WAIT, ARMED, HIGH, LOW} state_t;

  state_t state, state_nxt;

  logic din_s1, din_s2, din_d;
  logic rise, fall;

  logic [HW-1:0]          high_cnt;
  logic [LW-1:0]          low_cnt;
  logic [BW-1:0]          byte_idx;
  logic [2:0]             bit_cnt;
  logic [7:0]             byte_sr;
  logic                   overflow;
  logic [8*NUM_BYTES-1:0] shadow;

  logic go_armed, proto_err, bit_done, bit_val, eof, start_high, start_low;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      din_s1 <= 1'b0;
      din_s2 <= 1'b0;
      din_d  <= 1'b0;
    end else begin
      din_s1 <= din;
      din_s2 <= din_s1;
      din_d  <= din_s2;
    end
  end

  assign rise = din_s2 & ~din_d;
  assign fall = ~din_s2 & din_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= SYNC_WAIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    go_armed   = 1'b0;
    proto_err  = 1'b0;
    bit_done   = 1'b0;
    bit_val    = 1'b0;
    eof        = 1'b0;
    start_high = 1'b0;
    start_low  = 1'b0;
    case (state)
      SYNC_WAIT: begin
        if (!din_s2 && low_cnt == LOW_LAST) begin
          state_nxt = ARMED;
          go_armed  = 1'b1;
        end
      end
      ARMED: begin
        if (rise) begin
          state_nxt  = HIGH;
          start_high = 1'b1;
        end
      end
      HIGH: begin
        if (fall) begin
          if (high_cnt < HIGH_MIN) begin
            state_nxt = SYNC_WAIT;
            proto_err = 1'b1;
          end else begin
            state_nxt = LOW;
            bit_done  = 1'b1;
            bit_val   = (high_cnt >= HIGH_THR);
            start_low = 1'b1;
          end
        end else if (high_cnt == HIGH_LAST) begin
          state_nxt = SYNC_WAIT;
          proto_err = 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          state_nxt  = HIGH;
          start_high = 1'b1;
        end else if (low_cnt == LOW_LAST) begin
          state_nxt = ARMED;
          eof       = 1'b1;
          go_armed  = 1'b1;
        end
      end
      default: state_nxt = SYNC_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      high_cnt    <= '0;
      low_cnt     <= '0;
      byte_idx    <= '0;
      bit_cnt     <= '0;
      byte_sr     <= '0;
      overflow    <= 1'b0;
      shadow      <= '0;
      framebuf    <= '0;
      frame_valid <= 1'b0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      byte_valid  <= 1'b0;
      frame_err   <= proto_err;

      if (start_high)                          high_cnt <= HW'(1);
      else if (state == HIGH && high_cnt < HIGH_MAX) high_cnt <= high_cnt + HW'(1);

      // SYNC_WAIT counts only an unbroken low run; any high restarts it
      if (proto_err)                           low_cnt <= '0;
      else if (start_low)                      low_cnt <= LW'(1);
      else if (state == SYNC_WAIT && din_s2)   low_cnt <= '0;
      else if ((state == SYNC_WAIT || state == LOW) && low_cnt < LOW_MAX)
        low_cnt <= low_cnt + LW'(1);

      if (eof) begin
        if (byte_idx == BYTES_MAX && bit_cnt == 3'd0 && !overflow) begin
          framebuf    <= shadow;
          frame_valid <= 1'b1;
        end else if (!(byte_idx == '0 && bit_cnt == 3'd0 && !overflow)) begin
          frame_err <= 1'b1;
        end
      end

      if (go_armed) begin
        byte_idx <= '0;
        bit_cnt  <= '0;
        overflow <= 1'b0;
        shadow   <= '0;
      end else if (bit_done) begin
        byte_sr[bit_cnt] <= bit_val;
        bit_cnt          <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_data  <= {bit_val, byte_sr[6:0]};
          byte_valid <= 1'b1;
          if (byte_idx < BYTES_MAX) begin
            shadow[{byte_idx, 3'b000} +: 8] <= {bit_val, byte_sr[6:0]};
            byte_idx <= byte_idx + BW'(1);
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule
